// File: rtl/lzrw1_pkg.sv
// Shared types for the LZRW1 compressor front end: window depth, byte type
// and the input-window state encoding.
package lzrw1_pkg;
  localparam int WINDOW = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {FILL, RUN, DRAIN, DONE} window_state_t;
endpackage

// File: rtl/lzrw1_input_window.sv
// Byte-stream to 16-byte sliding lookahead window for the LZRW1 compressor.
// Slides one byte per pop; drains with zero padding after the last byte.
module lzrw1_input_window
  import lzrw1_pkg::*;
#(
  parameter int MAX_LEN = 4096
) (
  input  logic                           clock,
  input  logic                           reset,
  input  byte_t                          in_byte,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  input  logic                           win_ready,
  output logic [WINDOW-1:0][7:0]         cur_byte,
  output logic                           win_valid,
  output logic [4:0]                     valid_count,
  output logic [$clog2(MAX_LEN):0]       byte_count,
  output logic                           done
);

  localparam int BCW = $clog2(MAX_LEN) + 1;
  localparam int IW  = $clog2(WINDOW);

  window_state_t          r_state;
  logic [WINDOW-1:0][7:0] r_win;
  logic [4:0]             r_occ;
  logic [BCW-1:0]         r_bcnt;
  logic                   r_done;

  logic [WINDOW-1:0][7:0] w_win_nxt;
  logic [4:0]             w_occ_nxt;
  logic [IW-1:0]          w_wr_idx;
  logic                   w_acc;
  logic                   w_pop;
  logic                   w_last;

  assign win_valid = (r_state == RUN   && r_occ == 5'(WINDOW)) ||
                     (r_state == DRAIN && r_occ != 5'd0);
  assign w_pop     = win_valid && win_ready;
  // Gated by reset so upstream never sees a handshake while we are held in reset.
  assign in_ready  = reset && (r_state == FILL || r_state == RUN) &&
                     (r_occ < 5'(WINDOW) || w_pop);
  assign w_acc     = in_valid && in_ready;
  // Accepting byte MAX_LEN terminates the stream even without in_last.
  assign w_last    = in_last || (r_bcnt == BCW'(MAX_LEN - 1));
  assign w_wr_idx  = w_pop ? IW'(r_occ - 5'd1) : IW'(r_occ);

  always_comb begin
    w_win_nxt = r_win;
    if (w_pop) w_win_nxt = {8'h00, r_win[WINDOW-1:1]};
    if (w_acc) w_win_nxt[w_wr_idx] = in_byte;
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_acc && !w_pop)      w_occ_nxt = r_occ + 5'd1;
    else if (!w_acc && w_pop) w_occ_nxt = r_occ - 5'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= FILL;
      r_win   <= '0;
      r_occ   <= '0;
      r_bcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_win <= w_win_nxt;
      r_occ <= w_occ_nxt;
      if (w_acc && r_bcnt != BCW'(MAX_LEN)) r_bcnt <= r_bcnt + 1'b1;
      case (r_state)
        FILL, RUN: begin
          if (w_acc && w_last)
            r_state <= DRAIN;
          else if (r_state == FILL && w_occ_nxt == 5'(WINDOW))
            r_state <= RUN;
        end
        DRAIN: begin
          if (w_pop && r_occ == 5'd1) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= DONE;
      endcase
    end
  end

  assign cur_byte    = r_win;
  assign valid_count = r_occ;
  assign byte_count  = r_bcnt;
  assign done        = r_done;

endmodule

// File: tb/tb_lzrw1_input_window.sv
// Self-checking bench for lzrw1_input_window: a stream-level reference model
// (accepted bytes + pop position) checked every cycle, table-driven streams,
// and a mid-stream asynchronous reset sequence.
module tb_lzrw1_input_window;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic in_valid = 1'b0, in_last = 1'b0, win_ready = 1'b0;

  logic [15:0][7:0] cur0, cur1;
  logic rdy0, rdy1, wv0, wv1, done0, done1;
  logic [4:0] vc0, vc1;
  logic [12:0] bc0;
  logic [5:0] bc1;

  always #5 clk = ~clk;

  lzrw1_input_window #(.MAX_LEN(4096)) dut (
    .clock(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy0), .win_ready(win_ready),
    .cur_byte(cur0), .win_valid(wv0), .valid_count(vc0),
    .byte_count(bc0), .done(done0));

  lzrw1_input_window #(.MAX_LEN(32)) dut32 (
    .clock(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy1), .win_ready(win_ready),
    .cur_byte(cur1), .win_valid(wv1), .valid_count(vc1),
    .byte_count(bc1), .done(done1));

  // Both instances see identical inputs; sel32 picks which one is checked.
  logic sel32 = 1'b0;
  logic [15:0][7:0] o_cur;
  logic o_rdy, o_wv, o_done;
  logic [4:0] o_vc;
  logic [12:0] o_bc;
  assign o_cur  = sel32 ? cur1  : cur0;
  assign o_rdy  = sel32 ? rdy1  : rdy0;
  assign o_wv   = sel32 ? wv1   : wv0;
  assign o_done = sel32 ? done1 : done0;
  assign o_vc   = sel32 ? vc1   : vc0;
  assign o_bc   = sel32 ? {7'd0, bc1} : bc0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stream as a list of accepted bytes plus how many
  // have been popped. The window is simply the next 16 stream bytes.
  logic [7:0] m_str [64];
  int m_nacc = 0, m_pos = 0, m_ml = 4096;
  bit m_eos = 0, m_acc = 0, m_pop = 0;
  int occ;
  logic [15:0][7:0] e_win;
  bit e_wv, e_pop, e_rdy, e_done;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_cur", o_cur, '0);
      chk("rst_wv", o_wv, 0);
      chk("rst_vc", o_vc, 0);
      chk("rst_bc", o_bc, 0);
      chk("rst_done", o_done, 0);
      chk("rst_rdy", o_rdy, 0);
      m_nacc = 0; m_pos = 0; m_eos = 0; m_acc = 0; m_pop = 0;
    end else begin
      occ = m_nacc - m_pos;
      for (int i = 0; i < 16; i++) e_win[i] = (i < occ) ? m_str[m_pos + i] : 8'h00;
      e_wv   = m_eos ? (occ > 0) : (occ == 16);
      e_done = m_eos && occ == 0;
      e_pop  = e_wv && win_ready;
      e_rdy  = !m_eos && (occ < 16 || e_pop);
      chk("cur_byte", o_cur, e_win);
      chk("win_valid", o_wv, e_wv);
      chk("valid_count", o_vc, occ);
      chk("byte_count", o_bc, m_nacc);
      chk("done", o_done, e_done);
      chk("in_ready", o_rdy, e_rdy);
      m_acc = in_valid && e_rdy;
      m_pop = e_pop;
      if (m_acc) begin
        m_str[m_nacc] = in_byte;
        m_nacc++;
        if (in_last || m_nacc == m_ml) m_eos = 1;
      end
      if (m_pop) m_pos++;
    end
  end

  typedef struct {
    string nm;
    int    len;
    int    base;
    bit    rnd;
    bit    last;
    bit    ml32;
    int    vmode;   // 0 always valid, 1 every other cycle, 2 random
    int    rmode;   // 0 always ready, 1 five-cycle stall mid-RUN, 2 random
    int    exp_pops;
  } vec_t;

  logic [7:0] data [64];

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; win_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run(input vec_t v);
    int idx = 0, cyc = 0;
    bit seen = 0;
    sel32 = v.ml32;
    m_ml  = v.ml32 ? 32 : 4096;
    for (int i = 0; i < 64; i++) data[i] = v.rnd ? 8'($urandom) : 8'(v.base + i);
    while (!o_done && cyc < 600) begin
      in_valid = (idx < v.len) &&
                 (v.vmode == 0 || (v.vmode == 1 && cyc % 2 == 1) ||
                  (v.vmode == 2 && $urandom_range(1) == 1));
      in_byte  = (idx < 64) ? data[idx] : 8'h00;
      in_last  = v.last && idx == v.len - 1;
      win_ready = (v.rmode == 0) ? 1'b1 :
                  (v.rmode == 1) ? !(cyc >= 17 && cyc < 22) :
                                   ($urandom_range(9) < 6);
      @(posedge clk);
      if (m_acc) idx++;
      #1;
      cyc++;
      if (!seen && o_wv) begin
        seen = 1;
        chk({v.nm, ":first_cur0"}, o_cur[0], data[0]);
        if (v.len >= 16) chk({v.nm, ":first_cur15"}, o_cur[15], data[15]);
        else chk({v.nm, ":first_pad"}, o_cur >> (8 * v.len), '0);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk({v.nm, ":done"}, o_done, 1'b1);
    chk({v.nm, ":pops"}, m_pos, v.exp_pops);
    chk({v.nm, ":byte_count"}, o_bc, v.exp_pops);
  endtask

  vec_t tbl [9];

  initial begin
    vec_t rv;
    int cnt, cyc;
    tbl[0] = '{"seq20",    20, 'h00, 0, 1, 0, 0, 0, 20};
    tbl[1] = '{"stall",    20, 'h00, 0, 1, 0, 0, 1, 20};
    tbl[2] = '{"short5",    5, 'hA0, 0, 1, 0, 0, 0,  5};
    tbl[3] = '{"maxlen32", 40, 'h10, 0, 0, 1, 0, 0, 32};
    tbl[4] = '{"toggle",   20, 'h00, 0, 1, 0, 1, 0, 20};
    tbl[5] = '{"rand37",   37, 0,    1, 1, 0, 2, 2, 37};
    tbl[6] = '{"exact16",  16, 'h30, 0, 1, 0, 0, 0, 16};
    tbl[7] = '{"one",       1, 'h77, 0, 1, 0, 0, 0,  1};
    tbl[8] = '{"rand_ml",  50, 0,    1, 0, 1, 2, 2, 32};

    for (int t = 0; t < 9; t++) begin
      do_reset();
      run(tbl[t]);
    end

    // Mid-stream reset: 10 accepts, then async reset between clock edges.
    do_reset();
    sel32 = 0; m_ml = 4096;
    cnt = 0; cyc = 0;
    while (cnt < 10 && cyc < 100) begin
      in_valid = 1'b1; in_byte = 8'(8'hC0 + cnt); in_last = 1'b0; win_ready = 1'b1;
      @(posedge clk);
      if (m_acc) cnt++;
      #1;
      cyc++;
    end
    chk("pre_rst_vc", o_vc, 10);
    #2 reset = 1'b0;
    #1;
    chk("async_cur", o_cur, '0);
    chk("async_vc", o_vc, 0);
    chk("async_bc", o_bc, 0);
    chk("async_wv", o_wv, 0);
    chk("async_rdy", o_rdy, 0);
    chk("async_done", o_done, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    rv = '{"after_rst", 16, 'h50, 0, 1, 0, 0, 0, 16};
    run(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
